// File: rtl/vga_timing_pkg.sv
// Raster timing constants for the 640x480@60 default mode and the helpers
// that derive line/frame totals and sync-window bounds from porch widths.
package vga_timing_pkg;

   localparam int DEF_H_ACTIVE  = 640;
   localparam int DEF_H_FRONT   = 16;
   localparam int DEF_H_SYNC    = 96;
   localparam int DEF_H_BACK    = 48;
   localparam int DEF_V_ACTIVE  = 480;
   localparam int DEF_V_FRONT   = 10;
   localparam int DEF_V_SYNC    = 2;
   localparam int DEF_V_BACK    = 33;
   localparam int DEF_CW        = 11;
   localparam int DEF_LOOKAHEAD = 2;

   function automatic int axis_total(input int active, input int front,
                                     input int sync, input int back);
      return active + front + sync + back;
   endfunction

   // First count of the sync window (inclusive).
   function automatic int sync_first(input int active, input int front);
      return active + front;
   endfunction

   // One past the last count of the sync window (exclusive).
   function automatic int sync_end(input int active, input int front, input int sync);
      return active + front + sync;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping position counter for one raster axis, with active-area and
// sync-window decode of the current count.
module vga_axis_counter #(
   parameter int CW      = 11,
   parameter int TOTAL   = 800,
   parameter int ACTIVE  = 640,
   parameter int SYNC_LO = 656,
   parameter int SYNC_HI = 752,
   parameter int RST_VAL = 0
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_inc,
   output logic          o_wrap,
   output logic [CW-1:0] o_cnt,
   output logic          o_active,
   output logic          o_sync
);

   localparam logic [CW-1:0] LAST  = CW'(TOTAL - 1);
   localparam logic [CW-1:0] START = CW'(RST_VAL);
   localparam logic [CW-1:0] ACT   = CW'(ACTIVE);
   localparam logic [CW-1:0] S_LO  = CW'(SYNC_LO);
   localparam logic [CW-1:0] S_HI  = CW'(SYNC_HI);

   logic [CW-1:0] r_cnt;
   logic          w_at_last;

   assign w_at_last = (r_cnt == LAST);
   assign o_wrap    = i_inc & w_at_last;

   // Clear wins over increment so a stopped generator always parks at START.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= START;
      end else if (i_clr) begin
         r_cnt <= START;
      end else if (i_inc) begin
         r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
      end
   end

   assign o_cnt    = r_cnt;
   assign o_active = (r_cnt < ACT);
   assign o_sync   = (r_cnt >= S_LO) && (r_cnt < S_HI);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: syncs, data enable, coordinates,
// line/frame pulses and a lookahead fetch coordinate, stepped by pix_en.
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE  = DEF_H_ACTIVE,
   parameter int H_FRONT   = DEF_H_FRONT,
   parameter int H_SYNC    = DEF_H_SYNC,
   parameter int H_BACK    = DEF_H_BACK,
   parameter int V_ACTIVE  = DEF_V_ACTIVE,
   parameter int V_FRONT   = DEF_V_FRONT,
   parameter int V_SYNC    = DEF_V_SYNC,
   parameter int V_BACK    = DEF_V_BACK,
   parameter bit HS_POL    = 1'b0,
   parameter bit VS_POL    = 1'b0,
   parameter int CW        = DEF_CW,
   parameter int LOOKAHEAD = DEF_LOOKAHEAD
)(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          pix_en,
   input  logic          enable,
   output logic          vga_hs,
   output logic          vga_vs,
   output logic          is_drawing,
   output logic [CW-1:0] px,
   output logic [CW-1:0] py,
   output logic [CW-1:0] fetch_x,
   output logic [CW-1:0] fetch_y,
   output logic          fetch_valid,
   output logic          line_start,
   output logic          frame_start
);

   localparam int H_TOTAL = axis_total(H_ACTIVE, H_FRONT, H_SYNC, H_BACK);
   localparam int V_TOTAL = axis_total(V_ACTIVE, V_FRONT, V_SYNC, V_BACK);

   generate
      if ((H_TOTAL > 2**CW) || (V_TOTAL > 2**CW)) begin : g_cw_check
         $fatal(1, "vga_timing_gen: CW cannot hold H_TOTAL-1 / V_TOTAL-1");
      end
      if ((LOOKAHEAD < 0) || (LOOKAHEAD >= H_TOTAL)) begin : g_la_check
         $fatal(1, "vga_timing_gen: LOOKAHEAD must satisfy 0 <= LOOKAHEAD < H_TOTAL");
      end
   endgenerate

   logic          w_step;
   logic          w_clr;
   logic [CW-1:0] w_hc     [2];
   logic [CW-1:0] w_vc     [2];
   logic          w_h_wrap [2];
   logic          w_v_wrap [2];
   logic          w_h_act  [2];
   logic          w_v_act  [2];
   logic          w_h_sync [2];
   logic          w_v_sync [2];
   logic          w_unused;

   assign w_step = enable & pix_en;
   assign w_clr  = ~enable;

   // Pair 0 is the displayed position; pair 1 is the fetch position, which
   // starts LOOKAHEAD pixels into line 0 and then runs in lockstep.
   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_pair
         vga_axis_counter #(
            .CW      (CW),
            .TOTAL   (H_TOTAL),
            .ACTIVE  (H_ACTIVE),
            .SYNC_LO (sync_first(H_ACTIVE, H_FRONT)),
            .SYNC_HI (sync_end(H_ACTIVE, H_FRONT, H_SYNC)),
            .RST_VAL ((gi == 0) ? 0 : LOOKAHEAD)
         ) u_h (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_clr    (w_clr),
            .i_inc    (w_step),
            .o_wrap   (w_h_wrap[gi]),
            .o_cnt    (w_hc[gi]),
            .o_active (w_h_act[gi]),
            .o_sync   (w_h_sync[gi])
         );

         vga_axis_counter #(
            .CW      (CW),
            .TOTAL   (V_TOTAL),
            .ACTIVE  (V_ACTIVE),
            .SYNC_LO (sync_first(V_ACTIVE, V_FRONT)),
            .SYNC_HI (sync_end(V_ACTIVE, V_FRONT, V_SYNC)),
            .RST_VAL (0)
         ) u_v (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_clr    (w_clr),
            .i_inc    (w_h_wrap[gi]),
            .o_wrap   (w_v_wrap[gi]),
            .o_cnt    (w_vc[gi]),
            .o_active (w_v_act[gi]),
            .o_sync   (w_v_sync[gi])
         );
      end
   endgenerate

   assign w_unused = ^{w_h_sync[1], w_v_sync[1], w_v_wrap[0], w_v_wrap[1]};

   logic          r_hs, r_vs, r_de, r_fv, r_ls, r_fs;
   logic [CW-1:0] r_px, r_py, r_fx, r_fy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hs <= ~HS_POL;
         r_vs <= ~VS_POL;
         r_de <= 1'b0;
         r_fv <= 1'b0;
         r_ls <= 1'b0;
         r_fs <= 1'b0;
         r_px <= '0;
         r_py <= '0;
         r_fx <= '0;
         r_fy <= '0;
      end else if (!enable) begin
         r_hs <= ~HS_POL;
         r_vs <= ~VS_POL;
         r_de <= 1'b0;
         r_fv <= 1'b0;
         r_ls <= 1'b0;
         r_fs <= 1'b0;
         r_px <= '0;
         r_py <= '0;
         r_fx <= '0;
         r_fy <= '0;
      end else if (pix_en) begin
         r_hs <= w_h_sync[0] ? HS_POL : ~HS_POL;
         r_vs <= w_v_sync[0] ? VS_POL : ~VS_POL;
         r_de <= w_h_act[0] & w_v_act[0];
         r_fv <= w_h_act[1] & w_v_act[1];
         r_ls <= (w_hc[0] == '0);
         r_fs <= (w_hc[0] == '0) && (w_vc[0] == '0);
         r_px <= w_hc[0];
         r_py <= w_vc[0];
         r_fx <= w_hc[1];
         r_fy <= w_vc[1];
      end else begin
         // Held position, but pulses must not stretch across idle strobes.
         r_ls <= 1'b0;
         r_fs <= 1'b0;
      end
   end

   assign vga_hs      = r_hs;
   assign vga_vs      = r_vs;
   assign is_drawing  = r_de;
   assign fetch_valid = r_fv;
   assign line_start  = r_ls;
   assign frame_start = r_fs;
   assign px          = r_px;
   assign py          = r_py;
   assign fetch_x     = r_fx;
   assign fetch_y     = r_fy;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: two generator instances (wide mode with short frame,
// tiny mode with inverted polarities) checked every clock against a model.
module tb_vga_timing_gen;

   localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
   localparam int AVA = 12,  AVF = 2,  AVS = 2,  AVB = 3;
   localparam int ALA = 2;
   localparam int AFT = (AHA + AHF + AHS + AHB) * (AVA + AVF + AVS + AVB);
   localparam int BHA = 8, BHF = 2, BHS = 2, BHB = 2;
   localparam int BVA = 4, BVF = 1, BVS = 1, BVB = 1;
   localparam int BLA = 0;
   localparam int BFT = (BHA + BHF + BHS + BHB) * (BVA + BVF + BVS + BVB);

   typedef struct {
      int hs, vs, de, px, py, fx, fy, fv, ls, fs;
   } exp_t;

   int vec = 0;
   int err = 0;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_a_n = 1'b0, en_a = 1'b1, pix_a = 1'b1;
   logic rst_b_n = 1'b0, en_b = 1'b1, pix_b = 1'b1;
   logic done_b = 1'b0;

   logic        hs_a, vs_a, de_a, fv_a, ls_a, fs_a;
   logic [10:0] px_a, py_a, fx_a, fy_a;
   logic        hs_b, vs_b, de_b, fv_b, ls_b, fs_b;
   logic [3:0]  px_b, py_b, fx_b, fy_b;

   vga_timing_gen #(
      .H_ACTIVE(AHA), .H_FRONT(AHF), .H_SYNC(AHS), .H_BACK(AHB),
      .V_ACTIVE(AVA), .V_FRONT(AVF), .V_SYNC(AVS), .V_BACK(AVB),
      .HS_POL(1'b0), .VS_POL(1'b0), .CW(11), .LOOKAHEAD(ALA)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_a_n), .pix_en(pix_a), .enable(en_a),
      .vga_hs(hs_a), .vga_vs(vs_a), .is_drawing(de_a),
      .px(px_a), .py(py_a), .fetch_x(fx_a), .fetch_y(fy_a),
      .fetch_valid(fv_a), .line_start(ls_a), .frame_start(fs_a)
   );

   vga_timing_gen #(
      .H_ACTIVE(BHA), .H_FRONT(BHF), .H_SYNC(BHS), .H_BACK(BHB),
      .V_ACTIVE(BVA), .V_FRONT(BVF), .V_SYNC(BVS), .V_BACK(BVB),
      .HS_POL(1'b1), .VS_POL(1'b1), .CW(4), .LOOKAHEAD(BLA)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_b_n), .pix_en(pix_b), .enable(en_b),
      .vga_hs(hs_b), .vga_vs(vs_b), .is_drawing(de_b),
      .px(px_b), .py(py_b), .fetch_x(fx_b), .fetch_y(fy_b),
      .fetch_valid(fv_b), .line_start(ls_b), .frame_start(fs_b)
   );

   // Outputs for linear raster index n (strobes since frame origin).
   function automatic exp_t present(input int n, input int ha, input int hf,
                                    input int hsw, input int hb, input int va,
                                    input int vf, input int vsw, input int vb,
                                    input int hp, input int vp, input int la);
      exp_t e;
      int ht = ha + hf + hsw + hb;
      int vt = va + vf + vsw + vb;
      int h  = n % ht;
      int v  = n / ht;
      int m  = (n + la) % (ht * vt);
      e.hs = (h >= ha + hf && h < ha + hf + hsw) ? hp : 1 - hp;
      e.vs = (v >= va + vf && v < va + vf + vsw) ? vp : 1 - vp;
      e.de = (h < ha && v < va) ? 1 : 0;
      e.px = h;
      e.py = v;
      e.fx = m % ht;
      e.fy = m / ht;
      e.fv = (e.fx < ha && e.fy < va) ? 1 : 0;
      e.ls = (h == 0) ? 1 : 0;
      e.fs = (n == 0) ? 1 : 0;
      return e;
   endfunction

   function automatic exp_t idle(input int hp, input int vp);
      exp_t e;
      e = '{default: 0};
      e.hs = 1 - hp;
      e.vs = 1 - vp;
      return e;
   endfunction

   exp_t ea, eb;
   int   na, nb;

   always @(posedge clk or negedge rst_a_n) begin
      if (!rst_a_n || !en_a) begin
         ea <= idle(0, 0);
         na <= 0;
      end else if (pix_a) begin
         ea <= present(na, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB, 0, 0, ALA);
         na <= (na + 1) % AFT;
      end else begin
         ea.ls <= 0;
         ea.fs <= 0;
      end
   end

   always @(posedge clk or negedge rst_b_n) begin
      if (!rst_b_n || !en_b) begin
         eb <= idle(1, 1);
         nb <= 0;
      end else if (pix_b) begin
         eb <= present(nb, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB, 1, 1, BLA);
         nb <= (nb + 1) % BFT;
      end else begin
         eb.ls <= 0;
         eb.fs <= 0;
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("A.hs", 32'(hs_a), ea.hs);   chk("A.vs", 32'(vs_a), ea.vs);
      chk("A.de", 32'(de_a), ea.de);   chk("A.px", 32'(px_a), ea.px);
      chk("A.py", 32'(py_a), ea.py);   chk("A.fx", 32'(fx_a), ea.fx);
      chk("A.fy", 32'(fy_a), ea.fy);   chk("A.fv", 32'(fv_a), ea.fv);
      chk("A.ls", 32'(ls_a), ea.ls);   chk("A.fs", 32'(fs_a), ea.fs);
      chk("B.hs", 32'(hs_b), eb.hs);   chk("B.vs", 32'(vs_b), eb.vs);
      chk("B.de", 32'(de_b), eb.de);   chk("B.px", 32'(px_b), eb.px);
      chk("B.py", 32'(py_b), eb.py);   chk("B.fx", 32'(fx_b), eb.fx);
      chk("B.fy", 32'(fy_b), eb.fy);   chk("B.fv", 32'(fv_b), eb.fv);
      chk("B.ls", 32'(ls_b), eb.ls);   chk("B.fs", 32'(fs_b), eb.fs);
   end

   task automatic wait_pos_a(input int x, input int y, input int lim);
      int i = 0;
      while (!(32'(px_a) == x && 32'(py_a) == y) && i < lim) begin
         @(negedge clk);
         i++;
      end
      chk("A.wait_pos", 32'(32'(px_a) == x && 32'(py_a) == y), 1);
   endtask

   // Counts clks from the current frame_start to the next, optionally
   // toggling pix_en, and records the longest line_start run.
   task automatic measure(input bit tog, output int clks, output int maxw);
      int run = 0;
      clks = 0;
      maxw = 0;
      do begin
         if (tog) pix_a = ~pix_a;
         @(negedge clk);
         clks++;
         if (ls_a) begin
            run++;
            if (run > maxw) maxw = run;
         end else begin
            run = 0;
         end
      end while (!fs_a && clks < 40000);
   endtask

   initial begin
      int cnt, first, clks, maxw;
      @(posedge clk);
      #1;
      chk("A.rst_hs", 32'(hs_a), 1);  chk("A.rst_vs", 32'(vs_a), 1);
      chk("A.rst_de", 32'(de_a), 0);  chk("A.rst_px", 32'(px_a), 0);
      chk("A.rst_fx", 32'(fx_a), 0);  chk("A.rst_fs", 32'(fs_a), 0);
      repeat (2) @(negedge clk);
      rst_a_n = 1'b1;
      @(negedge clk);
      chk("A.first_fs", 32'(fs_a), 1); chk("A.first_px", 32'(px_a), 0);
      chk("A.first_fx", 32'(fx_a), 2); chk("A.first_fv", 32'(fv_a), 1);

      // Asynchronous reset mid-line.
      wait_pos_a(300, 0, 1000);
      @(posedge clk);
      #2 rst_a_n = 1'b0;
      #1;
      chk("A.midrst_hs", 32'(hs_a), 1); chk("A.midrst_vs", 32'(vs_a), 1);
      chk("A.midrst_de", 32'(de_a), 0); chk("A.midrst_px", 32'(px_a), 0);
      chk("A.midrst_py", 32'(py_a), 0);
      @(negedge clk);
      rst_a_n = 1'b1;
      @(negedge clk);
      chk("A.restart_fs", 32'(fs_a), 1); chk("A.restart_px", 32'(px_a), 0);

      cnt = 0;
      first = -1;
      for (int i = 0; i < 800; i++) begin
         if (!hs_a) begin
            cnt++;
            if (first < 0) first = 32'(px_a);
         end
         @(negedge clk);
      end
      chk("A.hsync_width", cnt, 96);
      chk("A.hsync_start", first, 656);

      wait_pos_a(798, 10, 20000);
      chk("A.la_fx", 32'(fx_a), 0);  chk("A.la_fy", 32'(fy_a), 11);
      chk("A.la_fv", 32'(fv_a), 1);  chk("A.model_fy", ea.fy, 11);

      cnt = 0;
      while (vs_a && cnt < 5000) begin
         @(negedge clk);
         cnt++;
      end
      chk("A.vsync_px", 32'(px_a), 0); chk("A.vsync_py", 32'(py_a), 14);
      cnt = 0;
      while (!vs_a && cnt < 5000) begin
         cnt++;
         @(negedge clk);
      end
      chk("A.vsync_clks", cnt, 1600);

      wait_pos_a(798, 18, 20000);
      chk("A.wrap_fx", 32'(fx_a), 0); chk("A.wrap_fy", 32'(fy_a), 0);
      chk("A.wrap_fv", 32'(fv_a), 1); chk("A.model_wrap_fy", ea.fy, 0);

      cnt = 0;
      while (!fs_a && cnt < 10) begin
         @(negedge clk);
         cnt++;
      end
      chk("A.fs_reached", 32'(fs_a), 1);
      measure(1'b0, clks, maxw);
      chk("A.frame_period", clks, 15200);
      chk("A.ls_width", maxw, 1);
      measure(1'b1, clks, maxw);
      chk("A.frame_period_half", clks, 30400);
      chk("A.ls_width_half", maxw, 1);

      pix_a = 1'b0;
      @(negedge clk);
      chk("A.hold_fs", 32'(fs_a), 0); chk("A.hold_ls", 32'(ls_a), 0);
      chk("A.hold_px", 32'(px_a), 0);
      pix_a = 1'b1;

      wait_pos_a(200, 5, 10000);
      en_a = 1'b0;
      @(negedge clk);
      chk("A.idle_px", 32'(px_a), 0); chk("A.idle_py", 32'(py_a), 0);
      chk("A.idle_hs", 32'(hs_a), 1); chk("A.idle_de", 32'(de_a), 0);
      repeat (4) @(negedge clk);
      en_a = 1'b1;
      @(negedge clk);
      chk("A.reen_fs", 32'(fs_a), 1); chk("A.reen_px", 32'(px_a), 0);
      chk("A.reen_py", 32'(py_a), 0);

      cnt = 0;
      while (!done_b && cnt < 20000) begin
         @(negedge clk);
         cnt++;
      end
      chk("B.done", 32'(done_b), 1);
      $display("== %0d vectors applied, %0d miscompares ==", vec, err);
      $finish;
   end

   initial begin
      int cnt, first;
      @(posedge clk);
      #1;
      chk("B.rst_hs", 32'(hs_b), 0); chk("B.rst_vs", 32'(vs_b), 0);
      repeat (2) @(negedge clk);
      rst_b_n = 1'b1;
      @(negedge clk);
      chk("B.first_fs", 32'(fs_b), 1);
      cnt = 0;
      first = -1;
      for (int i = 0; i < 14; i++) begin
         if (hs_b) begin
            cnt++;
            if (first < 0) first = 32'(px_b);
         end
         @(negedge clk);
      end
      chk("B.hsync_width", cnt, 2);
      chk("B.hsync_start", first, 10);

      repeat (200) @(negedge clk);
      en_b = 1'b0;
      repeat (3) @(negedge clk);
      en_b = 1'b1;
      repeat (50) @(negedge clk);
      for (int i = 0; i < 300; i++) begin
         pix_b = (i % 3 != 0);
         @(negedge clk);
      end
      pix_b = 1'b1;

      cnt = 0;
      while (!hs_b && cnt < 50) begin
         @(negedge clk);
         cnt++;
      end
      @(posedge clk);
      #2 rst_b_n = 1'b0;
      #1;
      chk("B.midsync_hs", 32'(hs_b), 0); chk("B.midsync_vs", 32'(vs_b), 0);
      chk("B.midsync_px", 32'(px_b), 0);
      @(negedge clk);
      rst_b_n = 1'b1;
      repeat (120) @(negedge clk);
      done_b = 1'b1;
   end

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("== %0d vectors applied, %0d miscompares ==", vec, err + 1);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised raster timing generator. It is the successor to the fixed 640x480 controller.
- Generates hsync, vsync, data-enable and pixel coordinates for any mode, with programmable sync polarity.
- Supports a pixel-clock-enable strobe, so the block runs from the system clock.
- Produces frame and line start pulses.
- Provides a lookahead fetch coordinate so framebuffer reads with fixed latency line up with the displayed pixel.
- Sits between the system clock domain and the video DAC/pixel pipeline.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FRONT, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BACK, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BACK, 33, vertical back porch (lines)
- HS_POL, 0, hsync asserted level (0 = active low)
- VS_POL, 0, vsync asserted level
- CW, 11, coordinate/counter width; must hold H_TOTAL-1 and V_TOTAL-1
- LOOKAHEAD, 2, fetch lead in pixels; 0 <= LOOKAHEAD < H_TOTAL

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- pix_en  in  1  pixel strobe; timing advances only on clk edges with pix_en=1
- enable  in  1  run control; low holds the generator idle at the origin
- vga_hs  out  1  horizontal sync, polarity HS_POL
- vga_vs  out  1  vertical sync, polarity VS_POL
- is_drawing  out  1  data enable; high in the active area
- px  out  CW  current horizontal count
- py  out  CW  current vertical count
- fetch_x  out  CW  horizontal count LOOKAHEAD pixels ahead of px
- fetch_y  out  CW  vertical count of that lookahead position
- fetch_valid  out  1  lookahead position lies in the active area
- line_start  out  1  one-clk pulse when outputs present h=0
- frame_start  out  1  one-clk pulse when outputs present (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FRONT+H_SYNC+H_BACK and V_TOTAL is defined the same way.
- Internal counters: h runs 0..H_TOTAL-1; v increments when h wraps and runs 0..V_TOTAL-1. There is no off-by-one: the period is exactly H_TOTAL by V_TOTAL strobes.
- Step: on a clk edge with rst_n=1, enable=1 and pix_en=1:
  - all registered outputs take values decoded from the current (h,v);
  - the counters then advance.
  - Latency is one strobe from counter to output.
- Decode:
  - is_drawing = h<H_ACTIVE && v<V_ACTIVE.
  - hsync is asserted for H_ACTIVE+H_FRONT <= h < H_ACTIVE+H_FRONT+H_SYNC, i.e. exactly H_SYNC pixels.
  - vsync is asserted over the analogous v window, i.e. exactly V_SYNC lines.
  - The output level is POL when asserted and ~POL otherwise.
  - Vsync edges coincide with the h=0 output of the line.
- px/py carry the raw counts throughout, including blanking; consumers gate on is_drawing.
- Lookahead: a second counter pair (fh,fv) advances in lockstep. Its reset value is the position LOOKAHEAD strobes after (0,0), wrapping across lines and frames (the fetch of the last LOOKAHEAD pixels of a frame points into the next frame's line 0). fetch_valid uses the same decode as is_drawing. With LOOKAHEAD=0, fetch outputs equal px/py.
- Pulses: line_start and frame_start are high for exactly one clk, the clk of the step that loads h=0 (and v=0 for frame_start) into the outputs. They are low on all other clks, including clks with pix_en=0.
- pix_en low: counters and all outputs hold; the pulses are cleared.
- enable low (synchronous, priority over pix_en): on the next clk the counters return to origin/lookahead reset values and outputs go idle. Re-asserting enable restarts at (0,0) with frame_start on the first strobe.
- Reset / idle values:
  - vga_hs=~HS_POL, vga_vs=~VS_POL;
  - is_drawing=0, fetch_valid=0, line_start=0, frame_start=0;
  - px=py=0, fetch_x=fetch_y=0.
  - Reset acts immediately, including mid-line or mid-sync.
- All compares are unsigned at CW bits. Parameter sanity (CW fits totals, LOOKAHEAD < H_TOTAL) is checked at elaboration with a fatal error.

Decomposition:
- Package vga_timing_pkg holds:
  - the 640x480@60 default constants;
  - derived H_TOTAL/V_TOTAL helper functions;
  - the sync-window bound functions.
- One sub-module is natural: vga_axis_counter. It is a wrap counter with an increment-in, a wrap-out, a reset-value parameter, and active/sync window decode. It is instantiated once per axis for the display pair and the fetch pair.

Test Plan:
- Async reset asserted mid-line at h=300 -> same cycle: vga_hs=1, vga_vs=1, is_drawing=0, px=py=0; after release with pix_en=1 the first step gives frame_start=1, px=0, py=0.
- Defaults, pix_en=1 constantly -> hsync low for exactly 96 strobes beginning at px=656; vsync low for 2 lines beginning at py=490,px=0; frame_start period exactly 420000 clks.
- pix_en toggling 1,0,1,0 -> all periods double to 840000 clks; frame_start and line_start stay one clk wide; outputs hold on pix_en=0 clks.
- LOOKAHEAD=2 -> when px=798,py=10 the bench sees fetch_x=0, fetch_y=11, fetch_valid=1; when px=798,py=524 it sees fetch_x=0, fetch_y=0.
- enable dropped at px=200,py=100 and raised 5 clks later -> idle outputs within 1 clk; restart presents (0,0) with frame_start=1.
- HS_POL=1, VS_POL=1, small mode (H 8/2/2/2, V 4/1/1/1) -> idle level 0; hs high exactly at h=10..11; full frame of 14x7 strobes matches a reference model.
